// File: rtl/crc_frame_checker_if.sv
// Handshake bundle for crc_frame_checker: framed word input and message FIFO output.
interface crc_frame_checker_if #(
    parameter int MESS_LEN = 12,
    parameter int CRC_LEN  = 4
);
    logic [MESS_LEN+CRC_LEN+1:0] in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [MESS_LEN-1:0]         out_data;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/crc_frame_checker.sv
// Receive-side CRC checker: serial polynomial division, good-message FIFO, error/drop counters.
// Optional macro CRC_STICKY_ALERT_EN makes LED_alert hold until rst or the next good frame.
module crc_frame_checker #(
    parameter int              MESS_LEN = 12,
    parameter int              CRC_LEN  = 4,
    parameter logic [CRC_LEN:0] POLY    = 5'b10011,
    parameter int              DEPTH    = 4,
    parameter int              CNT_W    = 6
) (
    input  logic               board_clk,
    input  logic               rst,
    crc_frame_checker_if.slave bus,
    output logic               LED_alert,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic               busy
);
    localparam int W  = MESS_LEN + CRC_LEN;
    localparam int IW = $clog2(MESS_LEN + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [W-1:0] POLY_TOP = W'(POLY) << (MESS_LEN - 1);
    localparam logic [W-1:0] LEAD_TOP = W'(1) << (W - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_CHECK} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [W-1:0]        r_div;
    logic [MESS_LEN-1:0] r_mess;
    logic                r_frame_ok;
    logic [IW-1:0]       r_i;
    logic [MESS_LEN-1:0] r_mem [DEPTH];
    logic [PW-1:0]       r_wr;
    logic [PW-1:0]       r_rd;
    logic [CW-1:0]       r_count;
    logic                r_led;
    logic [CNT_W-1:0]    r_err;
    logic [CNT_W-1:0]    r_drop;

    logic                w_accept;
    logic                w_check;
    logic                w_lead;
    logic                w_good;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_check  = (r_state == S_CHECK);
    // Leading bit of the current division step, walking MSB to LSB with r_i.
    assign w_lead   = |(r_div & (LEAD_TOP >> r_i));
    assign w_good   = r_frame_ok && (r_div[CRC_LEN-1:0] == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_pop    = (r_count != '0) && bus.out_ready;
    // A full FIFO can still take the message when its head leaves on the same edge.
    assign w_push   = w_check && w_good && (!w_full || w_pop);
    assign w_drop   = w_check && w_good && w_full && !w_pop;

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = r_mem[r_rd];
    assign busy          = (r_state != S_IDLE);
    assign LED_alert     = r_led;
    assign err_cnt       = r_err;
    assign drop_cnt      = r_drop;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = S_DIV;
            S_DIV:   if (r_i == IW'(MESS_LEN - 1)) w_next = S_CHECK;
            S_CHECK: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge board_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge board_clk) begin
        if (rst) begin
            r_div      <= '0;
            r_mess     <= '0;
            r_frame_ok <= 1'b0;
            r_i        <= '0;
        end else if (w_accept) begin
            r_div      <= bus.in_data[W:1];
            r_mess     <= bus.in_data[W:CRC_LEN+1];
            r_frame_ok <= bus.in_data[W+1] && !bus.in_data[0];
            r_i        <= '0;
        end else if (r_state == S_DIV) begin
            if (w_lead) r_div <= r_div ^ (POLY_TOP >> r_i);
            r_i <= r_i + 1'b1;
        end
    end

    always_ff @(posedge board_clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= r_mess;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge board_clk) begin
        if (rst) begin
            r_err  <= '0;
            r_drop <= '0;
            r_led  <= 1'b0;
        end else begin
            if (w_check && !w_good && (r_err != '1)) r_err <= r_err + 1'b1;
            if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
`ifdef CRC_STICKY_ALERT_EN
            if (w_check) r_led <= !w_good;
`else
            r_led <= w_check && !w_good;
`endif
        end
    end
endmodule
